// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction encoding, register codes and sequencer states.
// Used by the instruction sequencer and by the control FSM it feeds.
package cpu_pkg;

  localparam int unsigned DEF_INSTR_W = 10;
  localparam int unsigned DEF_ADDR_W  = 5;
  localparam int unsigned OP_W        = 4;
  localparam int unsigned ARG_W       = 3;

  typedef enum logic [OP_W-1:0] {
    OpLoad = 4'b0000,
    OpMove = 4'b0001,
    OpAdd  = 4'b0010,
    OpXor  = 4'b0011,
    OpNop  = 4'b1110,
    OpHalt = 4'b1111
  } opcode_e;

  typedef enum logic [ARG_W-1:0] {
    RegR0 = 3'd0,
    RegR1 = 3'd1,
    RegR2 = 3'd2,
    RegR3 = 3'd3,
    RegR4 = 3'd4,
    RegR5 = 3'd5,
    RegR6 = 3'd6,
    RegPc = 3'd7
  } reg_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StLatch  = 3'd2,
    StIssue  = 3'd3,
    StHalted = 3'd4
  } seq_state_e;

  // Instruction layout: {opcode, first register argument, second register argument}.
  function automatic logic [DEF_INSTR_W-1:0] make_instr(opcode_e op, reg_e ra, reg_e rb);
    return {op, ra, rb};
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Issue watchdog: counts ISSUE cycles without completion and flags expiry
// on the TIMEOUT-th such cycle.
module seq_watchdog #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Expiry is combinational so the sequencer can leave ISSUE on the same edge.
  assign expired = count_en && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches from a synchronous program ROM, presents each
// instruction to the control FSM until done, and advances or branches the PC.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_W = DEF_INSTR_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step,
  input  logic               halt_req,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instruction,
  input  logic               done,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_load_val,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               fault
);

  localparam logic [INSTR_W-1:0] NopInstr = {OpNop, {(INSTR_W - OP_W){1'b0}}};

  seq_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                step_mode_q, step_mode_d;
  logic                halt_pend_q, halt_pend_d;
  logic                fault_q, fault_d;
  logic                step_hold_q, step_hold_d;
  logic                step_new;
  logic                wd_clear, wd_en, wd_expired;

  assign busy     = (state_q == StFetch) || (state_q == StLatch) || (state_q == StIssue);
  assign halted   = (state_q == StHalted);
  assign fault    = fault_q;
  assign pc       = pc_q;
  assign mem_en   = (state_q == StFetch);
  assign mem_addr = mem_en ? pc_q : '0;

  // The control FSM only ever sees a real instruction while in ISSUE.
  assign instruction = (state_q == StIssue) ? instr_q : NopInstr;

  assign wd_clear = (state_q == StLatch);
  assign wd_en    = (state_q == StIssue) && !done;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear),
    .count_en (wd_en),
    .expired  (wd_expired)
  );

  // A step that stays high past its instruction must not start another one.
  assign step_new = step && !step_hold_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    step_mode_d = step_mode_q;
    fault_d     = fault_q;
    step_hold_d = step_hold_q && step;

    unique case (state_q)
      StIdle: begin
        if (run || step_new) begin
          state_d     = StFetch;
          step_mode_d = step_new && !run;
          fault_d     = 1'b0;
          step_hold_d = step;
        end
      end
      StFetch: begin
        state_d = StLatch;
      end
      StLatch: begin
        instr_d = mem_rdata;
        if (mem_rdata[INSTR_W-1 -: OP_W] == OpHalt) begin
          state_d = StHalted;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (done) begin
          pc_d = pc_load ? pc_load_val : pc_q + ADDR_W'(1);
          if (halt_pend_q || halt_req || step_mode_q || !run) begin
            state_d = StIdle;
          end else begin
            state_d = StFetch;
          end
        end else if (wd_expired) begin
          fault_d = 1'b1;
          state_d = StIdle;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d == StIdle) begin
      halt_pend_d = 1'b0;
    end else if (busy && halt_req) begin
      halt_pend_d = 1'b1;
    end else begin
      halt_pend_d = halt_pend_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      instr_q     <= NopInstr;
      step_mode_q <= 1'b0;
      halt_pend_q <= 1'b0;
      fault_q     <= 1'b0;
      step_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      step_mode_q <= step_mode_d;
      halt_pend_q <= halt_pend_d;
      fault_q     <= fault_d;
      step_hold_q <= step_hold_d;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: ROM and done-latency model, table-driven single steps,
// hand-written corner sequences and a randomized run against a PC-walk model.
module tb_instr_sequencer;
  import cpu_pkg::*;

  localparam int unsigned IW = 10;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst, run, step, halt_req;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_rdata;
  logic [IW-1:0] instruction;
  logic          done, pc_load;
  logic [AW-1:0] pc_load_val, pc;
  logic          busy, halted, fault;

  logic          tb_load, drv_load;
  logic [AW-1:0] tb_val, drv_val;
  logic          auto_done, force_done, rand_lat, rand_branch;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [AW-1:0] model_pc;

  typedef struct {
    logic [IW-1:0] instr;
    logic          ld;
    logic [AW-1:0] val;
  } issue_t;
  issue_t issue_log[$];

  logic [IW-1:0] rom [32];
  logic [IW-1:0] nop_i;
  logic [IW-1:0] halt_i;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= rom[mem_addr];

  assign pc_load     = rand_branch ? drv_load : tb_load;
  assign pc_load_val = rand_branch ? drv_val : tb_val;

  instr_sequencer #(
    .INSTR_W (IW),
    .ADDR_W  (AW),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .step        (step),
    .halt_req    (halt_req),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .instruction (instruction),
    .done        (done),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .fault       (fault)
  );

  function automatic int lat_of(input logic [3:0] op);
    case (op)
      4'b0000: return 1;
      4'b0001: return 1;
      4'b0010: return 3;
      4'b0011: return 2;
      default: return 1;
    endcase
  endfunction

  // Control-FSM model: raises done after a per-opcode number of ISSUE cycles.
  initial begin
    int cnt;
    int lat;
    issue_t rec;
    cnt = 0;
    lat = 1;
    done = 1'b0;
    drv_load = 1'b0;
    drv_val = '0;
    forever begin
      @(negedge clk);
      done = force_done;
      drv_load = 1'b0;
      if (instruction !== nop_i) begin
        cnt++;
        if (cnt == 1) lat = rand_lat ? int'($urandom_range(1, 4)) : lat_of(instruction[9:6]);
        if (auto_done && cnt >= lat) begin
          done = 1'b1;
          drv_load = 1'($urandom_range(0, 1));
          drv_val = AW'($urandom);
          rec.instr = instruction;
          rec.ld = rand_branch ? drv_load : tb_load;
          rec.val = rand_branch ? drv_val : tb_val;
          issue_log.push_back(rec);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired, got timeout, expected completion", name);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) timeout_fail(name);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic do_reset();
    run = 1'b0;
    step = 1'b0;
    halt_req = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    model_pc = '0;
  endtask

  task automatic goto_pc(input logic [AW-1:0] target);
    rom[model_pc] = make_instr(OpLoad, RegR1, RegR0);
    tb_load = 1'b1;
    tb_val = target;
    pulse_step();
    wait_idle("goto_idle", 20);
    tb_load = 1'b0;
    model_pc = target;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] instr;
    logic          ld;
    logic [AW-1:0] val;
    logic [AW-1:0] exp_pc;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [IW-1:0] seq_q[$];
    logic [IW-1:0] exp_seq[5];
    logic [AW-1:0] fetch_q[$];
    logic [AW-1:0] pc_e;
    int cnt;
    bit ok;

    nop_i = {4'b1110, 6'b0};
    halt_i = {4'b1111, 6'b0};
    for (int i = 0; i < 32; i++) rom[i] = halt_i;
    run = 1'b0; step = 1'b0; halt_req = 1'b0;
    tb_load = 1'b0; tb_val = '0;
    auto_done = 1'b1; force_done = 1'b0; rand_lat = 1'b0; rand_branch = 1'b0;
    model_pc = '0;

    vecs[0] = '{5'd5,  make_instr(OpMove, RegR3, RegR4), 1'b0, 5'd0,  5'd6};
    vecs[1] = '{5'd31, make_instr(OpLoad, RegR1, RegR0), 1'b0, 5'd0,  5'd0};
    vecs[2] = '{5'd7,  make_instr(OpAdd,  RegR2, RegR5), 1'b1, 5'd12, 5'd12};
    vecs[3] = '{5'd0,  make_instr(OpXor,  RegR6, RegPc), 1'b1, 5'd31, 5'd31};
    vecs[4] = '{5'd20, make_instr(OpAdd,  RegR6, RegPc), 1'b0, 5'd0,  5'd21};
    vecs[5] = '{5'd12, make_instr(OpLoad, RegR0, RegR1), 1'b1, 5'd3,  5'd3};

    // Reset values while held in reset.
    rst = 1'b0;
    #1;
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_instruction", instruction, nop_i);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    tick();
    rst = 1'b1;
    tick();

    // Small program run to HALT.
    rom[0] = make_instr(OpLoad, RegR1, RegR0);
    rom[1] = make_instr(OpAdd, RegR1, RegR2);
    rom[2] = halt_i;
    exp_seq[0] = nop_i;
    exp_seq[1] = rom[0];
    exp_seq[2] = nop_i;
    exp_seq[3] = rom[1];
    exp_seq[4] = nop_i;
    seq_q.push_back(instruction);
    run = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (instruction !== seq_q[$]) seq_q.push_back(instruction);
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("prog_halt");
    check("prog_seq_len", seq_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("prog_seq_%0d", i), (i < seq_q.size()) ? seq_q[i] : 'x, exp_seq[i]);
    end
    check("prog_halted", halted, 1);
    check("prog_pc", pc, 2);
    check("prog_busy", busy, 0);
    // run and step must be ignored while halted.
    pulse_step();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_en) cnt++;
    end
    check("halted_no_fetch", cnt, 0);
    check("halted_stays", halted, 1);
    do_reset();
    check("halted_rst_clears", halted, 0);

    // Table of single-step executions.
    for (int v = 0; v < 6; v++) begin
      goto_pc(vecs[v].addr);
      rom[vecs[v].addr] = vecs[v].instr;
      tb_load = vecs[v].ld;
      tb_val = vecs[v].val;
      issue_log.delete();
      pulse_step();
      wait_idle($sformatf("vec%0d_idle", v), 20);
      tb_load = 1'b0;
      check($sformatf("vec%0d_count", v), issue_log.size(), 1);
      check($sformatf("vec%0d_instr", v),
            (issue_log.size() > 0) ? issue_log[0].instr : 'x, vecs[v].instr);
      check($sformatf("vec%0d_pc", v), pc, vecs[v].exp_pc);
      model_pc = vecs[v].exp_pc;
    end

    // Step held high across a whole instruction executes it only once.
    goto_pc(5'd5);
    rom[5] = make_instr(OpMove, RegR2, RegR4);
    issue_log.delete();
    step = 1'b1;
    repeat (6) tick();
    step = 1'b0;
    wait_idle("hold_idle", 20);
    repeat (3) tick();
    check("hold_count", issue_log.size(), 1);
    check("hold_pc", pc, 6);
    check("hold_busy", busy, 0);
    model_pc = 5'd6;

    // done and pc_load outside ISSUE change nothing.
    force_done = 1'b1;
    tb_load = 1'b1;
    tb_val = 5'd17;
    repeat (3) tick();
    force_done = 1'b0;
    tb_load = 1'b0;
    tick();
    check("stray_done_pc", pc, model_pc);
    check("stray_done_busy", busy, 0);

    // halt_req in IDLE is ignored; in a busy state it stops after the current instruction.
    do_reset();
    for (int i = 0; i < 10; i++) rom[i] = make_instr(OpLoad, RegR2, RegR3);
    issue_log.delete();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    run = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (issue_log.size() >= 2) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) timeout_fail("halt_two_issues");
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_idle("halt_idle", 20);
    run = 1'b0;
    check("halt_count", issue_log.size(), 3);
    check("halt_pc", pc, 3);
    check("halt_not_halted", halted, 0);

    // Watchdog: done withheld, pc_load presented without done.
    do_reset();
    rom[0] = make_instr(OpAdd, RegR1, RegR2);
    auto_done = 1'b0;
    tb_load = 1'b1;
    tb_val = 5'd9;
    pulse_step();
    cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (instruction !== nop_i) cnt++;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("wd_idle");
    check("wd_issue_cycles", cnt, 8);
    check("wd_fault", fault, 1);
    check("wd_pc", pc, 0);
    check("wd_busy", busy, 0);
    auto_done = 1'b1;
    tb_load = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    check("wd_run_clears_fault", fault, 0);
    wait_idle("wd_rerun_idle", 20);
    check("wd_rerun_pc", pc, 1);

    // Asynchronous reset in the middle of ISSUE.
    do_reset();
    goto_pc(5'd3);
    rom[3] = make_instr(OpAdd, RegR1, RegR2);
    pulse_step();
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (instruction === rom[3]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) timeout_fail("rst_issue_reach");
    rst = 1'b0;
    #1;
    check("rstmid_pc", pc, 0);
    check("rstmid_instr", instruction, nop_i);
    check("rstmid_busy", busy, 0);
    tick();
    rst = 1'b1;
    tick();
    check("rstmid_after_instr", instruction, nop_i);
    check("rstmid_after_pc", pc, 0);
    model_pc = '0;

    // PC wrap 31 -> 0 in run mode, then fetch address.
    goto_pc(5'd31);
    rom[31] = make_instr(OpLoad, RegR2, RegR3);
    rom[0] = halt_i;
    fetch_q.delete();
    run = 1'b1;
    for (int i = 0; i < 30 && !halted; i++) begin
      tick();
      if (mem_en) fetch_q.push_back(mem_addr);
    end
    run = 1'b0;
    check("wrap_fetches", fetch_q.size(), 2);
    check("wrap_fetch0", (fetch_q.size() > 0) ? fetch_q[0] : 'x, 31);
    check("wrap_fetch1", (fetch_q.size() > 1) ? fetch_q[1] : 'x, 0);
    check("wrap_pc", pc, 0);
    check("wrap_halted", halted, 1);

    // Branch with done: next fetch from the target.
    do_reset();
    rom[0] = make_instr(OpAdd, RegR4, RegR5);
    rom[12] = halt_i;
    tb_load = 1'b1;
    tb_val = 5'd12;
    fetch_q.delete();
    run = 1'b1;
    for (int i = 0; i < 30 && !halted; i++) begin
      tick();
      if (mem_en) fetch_q.push_back(mem_addr);
    end
    run = 1'b0;
    tb_load = 1'b0;
    check("br_fetch1", (fetch_q.size() > 1) ? fetch_q[1] : 'x, 12);
    check("br_pc", pc, 12);
    check("br_halted", halted, 1);

    // Randomized runs: random program, latencies and branches vs. a PC-walk model.
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int i = 0; i < 32; i++) rom[i] = {2'b00, 2'($urandom), 6'($urandom)};
      issue_log.delete();
      rand_branch = 1'b1;
      rand_lat = 1'b1;
      run = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 800; i++) begin
        if (issue_log.size() >= 30) begin
          ok = 1'b1;
          break;
        end
        tick();
      end
      if (!ok) timeout_fail("rand_progress");
      run = 1'b0;
      wait_idle("rand_idle", 20);
      rand_branch = 1'b0;
      rand_lat = 1'b0;
      pc_e = '0;
      foreach (issue_log[k]) begin
        check($sformatf("rand%0d_instr%0d", r, k), issue_log[k].instr, rom[pc_e]);
        pc_e = issue_log[k].ld ? issue_log[k].val : AW'(pc_e + 1);
      end
      check($sformatf("rand%0d_pc", r), pc, pc_e);
      check($sformatf("rand%0d_fault", r), fault, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter INSTR_W, default 10, instruction width (4-bit opcode plus two 3-bit register arguments) presented to the control FSM.
REQ-002 Parameter ADDR_W, default 5, program-memory address and PC width.
REQ-003 Parameter TIMEOUT, default 8, maximum number of ISSUE cycles allowed before done must arrive.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 run  input  1  level; while high, the block executes instructions back-to-back.
REQ-007 step  input  1  single-cycle pulse; executes exactly one instruction when the block is IDLE.
REQ-008 halt_req  input  1  pulse; stop after the current instruction completes.
REQ-009 mem_en  output  1  program-memory read strobe.
REQ-010 mem_addr  output  ADDR_W  program-memory read address.
REQ-011 mem_rdata  input  INSTR_W  synchronous ROM data, valid the cycle after mem_en.
REQ-012 instruction  output  INSTR_W  instruction driven to the control FSM.
REQ-013 done  input  1  completion pulse from the control FSM.
REQ-014 pc_load  input  1  branch request: replaces the PC increment on done.
REQ-015 pc_load_val  input  ADDR_W  branch target.
REQ-016 pc  output  ADDR_W  current program counter.
REQ-017 busy  output  1  high in the FETCH, LATCH and ISSUE states.
REQ-018 halted  output  1  high in the HALTED state.
REQ-019 fault  output  1  sticky watchdog error flag.

Function
REQ-020 The block SHALL implement five states: IDLE, FETCH, LATCH, ISSUE and HALTED.
REQ-021 IDLE: run=1 or step=1 SHALL move to FETCH; if both are high, they SHALL be treated as run; on entry the block SHALL record step_mode = step & ~run and clear fault.
REQ-022 FETCH: the block SHALL assert mem_en=1 with mem_addr=pc for exactly one cycle, then move to LATCH.
REQ-023 LATCH: the block SHALL capture mem_rdata into instr_reg.
  - If opcode == HALT (4'b1111), it SHALL go to HALTED.
  - Otherwise it SHALL go to ISSUE and clear the watchdog counter.
REQ-024 ISSUE: the block SHALL drive instruction = instr_reg; in every other state it SHALL drive NOP (4'b1110, args 0).
REQ-025 ISSUE with done=1: the PC SHALL update on the same edge, to pc_load_val if pc_load=1, else pc+1, wrapping modulo 2^ADDR_W (all-ones goes to 0).
REQ-026 After that done, the next state SHALL be:
  - IDLE if halt_req is pending, step_mode=1, or run=0;
  - otherwise FETCH.
  - Fetch-to-issue latency is 2 cycles; minimum spacing between issues is 3 cycles.
REQ-027 A halt_req pulse in any busy state SHALL set a pending flag, cleared on entry to IDLE; halt_req in IDLE SHALL be ignored.
REQ-028 done outside ISSUE SHALL be ignored.
REQ-029 pc_load without done SHALL be ignored.
REQ-030 Watchdog: the counter SHALL increment each ISSUE cycle without done; reaching TIMEOUT SHALL set fault=1, leave the PC unchanged, and go to IDLE.
REQ-031 HALTED SHALL be exited only by reset; run and step SHALL be ignored there.
REQ-032 step held for several cycles SHALL execute one instruction; a new step is accepted only after returning to IDLE.

Reset
REQ-033 rst low SHALL asynchronously force:
  - state=IDLE, pc=0, instr_reg=NOP, step_mode=0;
  - halt pending=0, watchdog=0;
  - mem_en=0, mem_addr=0, instruction=NOP;
  - busy=0, halted=0, fault=0.
REQ-034 Reset mid-ISSUE SHALL abandon the instruction with no PC update; the control FSM sees NOP on the first cycle after release.

Structure
REQ-035 The opcode constants (LOAD, MOVE, ADD, XOR, NOP, HALT), the register codes R0-R6/PC, and the INSTR_W/ADDR_W defaults SHALL live in a shared package cpu_pkg, used by both this block and the control FSM.
REQ-036 The watchdog SHALL be one sub-module, seq_watchdog (clear, count enable, expired output); everything else stays in the top module.

Verification
REQ-037 Program the ROM with LOAD R1 at 0, ADD R1,R2 at 1, HALT at 2; run=1 with a done model (LOAD: 1 cycle, ADD: 3 cycles) -> instruction sequence NOP, LOAD, NOP, ADD, halted=1 with pc=2.
REQ-038 step pulse held 4 cycles with MOVE at pc=5 -> exactly one MOVE issued, pc=6, return to IDLE, busy=0.
REQ-039 pc=31 with done (no pc_load) -> pc=0, next mem_addr=0.
REQ-040 done together with pc_load=1, pc_load_val=12 -> pc=12, next fetch at address 12.
REQ-041 Done withheld for 8 ISSUE cycles -> fault=1, state IDLE, pc unchanged; a later run clears fault.
REQ-042 rst low during ISSUE of ADD at pc=3 -> pc=0, instruction=NOP immediately, busy=0.
